ex_seg_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures the decoder's control bundle plus ID-stage operands, PC and register indices each cycle.
- Hosts the load-use interlock: inserts one bubble into EX and tells IF/ID to hold.
- Honours the global stall enable and branch/jump flushes, and counts interlock bubbles for performance debug.

---
 rtl/ex_seg_reg_pkg.sv | 64 ++++++
 rtl/ex_seg_reg_if.sv | 65 ++++++
 rtl/ex_seg_reg_load_use_detect.sv | 32 +++
 rtl/ex_seg_reg.sv | 117 +++++++++++
 tb/tb_ex_seg_reg.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_seg_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_seg_reg_pkg
// Purpose  : Shared decoder encodings and the ID/EX control bundle layout.
//            The bubble encoding (all zero) is the same value the decoder
//            uses for "no write / no branch".
// Revision : 1.0 - initial release
// ============================================================================
package ex_seg_reg_pkg;

  // Register write modes; LW doubles as the full-word mode for ALU results
  typedef enum logic [2:0] {
    NOREGWRITE = 3'd0,
    LB         = 3'd1,
    LH         = 3'd2,
    LW         = 3'd3,
    LBU        = 3'd4,
    LHU        = 3'd5
  } reg_write_t;

  // Conditional branch types
  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } branch_type_t;

  // ALU functions
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_LUI  = 4'd10
  } alu_op_t;

  // Decoder control bundle carried from ID into EX
  typedef struct packed {
    logic [2:0] reg_write;
    logic       mem_to_reg;
    logic [3:0] mem_write;
    logic       load_npc;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic       alu_src1;
    logic [1:0] alu_src2;
  } ctrl_t;

  // A bubble carries no write, no store and no branch
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/ex_seg_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_seg_reg_if
// Purpose  : ID-side inputs and EX-side outputs of the ID/EX segment register.
//            master = ID stage / hazard consumer, slave = the segment register.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_seg_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic            en;
  logic            clear;

  logic [XLEN-1:0] pc_d,  rd1_d, rd2_d, imm_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [2:0]      reg_write_d;
  logic            mem_to_reg_d;
  logic [3:0]      mem_write_d;
  logic            load_npc_d;
  logic [1:0]      reg_read_d;
  logic [2:0]      branch_type_d;
  logic [3:0]      alu_ctrl_d;
  logic            alu_src1_d;
  logic [1:0]      alu_src2_d;

  logic [XLEN-1:0] pc_e,  rd1_e, rd2_e, imm_e;
  logic [4:0]      rs1_e, rs2_e, rd_e;
  logic [2:0]      reg_write_e;
  logic            mem_to_reg_e;
  logic [3:0]      mem_write_e;
  logic            load_npc_e;
  logic [1:0]      reg_read_e;
  logic [2:0]      branch_type_e;
  logic [3:0]      alu_ctrl_e;
  logic            alu_src1_e;
  logic [1:0]      alu_src2_e;

  logic            valid_e;
  logic            stall_fd;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output en, clear,
    output pc_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d,
    output reg_write_d, mem_to_reg_d, mem_write_d, load_npc_d, reg_read_d,
    output branch_type_d, alu_ctrl_d, alu_src1_d, alu_src2_d,
    input  pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
    input  reg_write_e, mem_to_reg_e, mem_write_e, load_npc_e, reg_read_e,
    input  branch_type_e, alu_ctrl_e, alu_src1_e, alu_src2_e,
    input  valid_e, stall_fd, bubble_cnt
  );

  modport slave (
    input  en, clear,
    input  pc_d, rd1_d, rd2_d, imm_d, rs1_d, rs2_d, rd_d,
    input  reg_write_d, mem_to_reg_d, mem_write_d, load_npc_d, reg_read_d,
    input  branch_type_d, alu_ctrl_d, alu_src1_d, alu_src2_d,
    output pc_e, rd1_e, rd2_e, imm_e, rs1_e, rs2_e, rd_e,
    output reg_write_e, mem_to_reg_e, mem_write_e, load_npc_e, reg_read_e,
    output branch_type_e, alu_ctrl_e, alu_src1_e, alu_src2_e,
    output valid_e, stall_fd, bubble_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ex_seg_reg_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module   : ex_seg_reg_load_use_detect
// Purpose  : Combinational load-use hazard detector. Flags when the load in
//            EX writes a register that the ID instruction actually reads.
// Revision : 1.0 - initial release
// ============================================================================
module ex_seg_reg_load_use_detect
  import ex_seg_reg_pkg::*;
(
  input  wire logic       valid_e,
  input  wire logic       mem_to_reg_e,
  input  wire logic [2:0] reg_write_e,
  input  wire logic [4:0] rd_e,
  input  wire logic [4:0] rs1_d,
  input  wire logic [4:0] rs2_d,
  input  wire logic [1:0] reg_read_d,
  output logic            lu
);
  logic w_ex_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never needs an interlock
  assign w_ex_load = valid_e & mem_to_reg_e & (reg_write_e != NOREGWRITE) & (rd_e != 5'd0);
  // Index fields of unused operands are don't-care bits of the encoding
  assign w_rs1_hit = reg_read_d[1] & (rs1_d == rd_e);
  assign w_rs2_hit = reg_read_d[0] & (rs2_d == rd_e);
  assign lu        = w_ex_load & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/ex_seg_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_seg_reg
// Purpose  : ID/EX pipeline register with load-use interlock, flush, global
//            stall and a saturating interlock-bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module ex_seg_reg
  import ex_seg_reg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  ex_seg_reg_if.slave bus
);
  logic [XLEN-1:0]  r_pc, r_rd1, r_rd2, r_imm;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  ctrl_t            r_ctrl;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;

  ctrl_t            w_id_ctrl;
  logic             w_lu;

  // Gather the decoder's control fields into one bundle
  always_comb begin
    w_id_ctrl             = CTRL_BUBBLE;
    w_id_ctrl.reg_write   = bus.reg_write_d;
    w_id_ctrl.mem_to_reg  = bus.mem_to_reg_d;
    w_id_ctrl.mem_write   = bus.mem_write_d;
    w_id_ctrl.load_npc    = bus.load_npc_d;
    w_id_ctrl.reg_read    = bus.reg_read_d;
    w_id_ctrl.branch_type = bus.branch_type_d;
    w_id_ctrl.alu_ctrl    = bus.alu_ctrl_d;
    w_id_ctrl.alu_src1    = bus.alu_src1_d;
    w_id_ctrl.alu_src2    = bus.alu_src2_d;
  end

  ex_seg_reg_load_use_detect u_lu (
    .valid_e      (r_valid),
    .mem_to_reg_e (r_ctrl.mem_to_reg),
    .reg_write_e  (r_ctrl.reg_write),
    .rd_e         (r_rd),
    .rs1_d        (bus.rs1_d),
    .rs2_d        (bus.rs2_d),
    .reg_read_d   (bus.reg_read_d),
    .lu           (w_lu)
  );

  // A flushed ID instruction is discarded, so it must not hold IF/ID
  assign bus.stall_fd = w_lu & ~bus.clear;

  // Pipeline register: hold on stall, bubble on flush/hazard, else advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_imm   <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_ctrl  <= CTRL_BUBBLE;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (bus.en) begin
      if (bus.clear || w_lu) begin
        r_pc    <= '0;
        r_rd1   <= '0;
        r_rd2   <= '0;
        r_imm   <= '0;
        r_rs1   <= '0;
        r_rs2   <= '0;
        r_rd    <= '0;
        r_ctrl  <= CTRL_BUBBLE;
        r_valid <= 1'b0;
        // Only interlock bubbles are counted; flush bubbles are not
        if (!bus.clear && !(&r_cnt)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_pc    <= bus.pc_d;
        r_rd1   <= bus.rd1_d;
        r_rd2   <= bus.rd2_d;
        r_imm   <= bus.imm_d;
        r_rs1   <= bus.rs1_d;
        r_rs2   <= bus.rs2_d;
        r_rd    <= bus.rd_d;
        r_ctrl  <= w_id_ctrl;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.pc_e          = r_pc;
  assign bus.rd1_e         = r_rd1;
  assign bus.rd2_e         = r_rd2;
  assign bus.imm_e         = r_imm;
  assign bus.rs1_e         = r_rs1;
  assign bus.rs2_e         = r_rs2;
  assign bus.rd_e          = r_rd;
  assign bus.reg_write_e   = r_ctrl.reg_write;
  assign bus.mem_to_reg_e  = r_ctrl.mem_to_reg;
  assign bus.mem_write_e   = r_ctrl.mem_write;
  assign bus.load_npc_e    = r_ctrl.load_npc;
  assign bus.reg_read_e    = r_ctrl.reg_read;
  assign bus.branch_type_e = r_ctrl.branch_type;
  assign bus.alu_ctrl_e    = r_ctrl.alu_ctrl;
  assign bus.alu_src1_e    = r_ctrl.alu_src1;
  assign bus.alu_src2_e    = r_ctrl.alu_src2;
  assign bus.valid_e       = r_valid;
  assign bus.bubble_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_seg_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_seg_reg
// Purpose  : Directed self-checking bench for ex_seg_reg (counter width 2 so
//            saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_seg_reg;
  import ex_seg_reg_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam int AW    = 4 * XLEN + 15 + 21;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [AW-1:0] w_all_e;
  logic [AW-1:0] r_drv;
  logic [AW-1:0] r_held;

  ex_seg_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  ex_seg_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign w_all_e = {bus.pc_e, bus.rd1_e, bus.rd2_e, bus.imm_e, bus.rs1_e, bus.rs2_e, bus.rd_e,
                    bus.reg_write_e, bus.mem_to_reg_e, bus.mem_write_e, bus.load_npc_e,
                    bus.reg_read_e, bus.branch_type_e, bus.alu_ctrl_e, bus.alu_src1_e,
                    bus.alu_src2_e};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the ID-stage fields and remember them as the expected EX image
  task automatic drive(input logic [31:0] pc, rd1, rd2, imm, input logic [4:0] rs1, rs2, rd,
                       input logic [2:0] rw, input logic m2r, input logic [3:0] mw,
                       input logic npc, input logic [1:0] rr, input logic [2:0] bt,
                       input logic [3:0] alu, input logic s1, input logic [1:0] s2);
    bus.pc_d = pc;   bus.rd1_d = rd1; bus.rd2_d = rd2; bus.imm_d = imm;
    bus.rs1_d = rs1; bus.rs2_d = rs2; bus.rd_d = rd;
    bus.reg_write_d = rw; bus.mem_to_reg_d = m2r; bus.mem_write_d = mw;
    bus.load_npc_d = npc; bus.reg_read_d = rr; bus.branch_type_d = bt;
    bus.alu_ctrl_d = alu; bus.alu_src1_d = s1; bus.alu_src2_d = s2;
    r_drv = {pc, rd1, rd2, imm, rs1, rs2, rd, rw, m2r, mw, npc, rr, bt, alu, s1, s2};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Common instruction shapes
  task automatic drv_lw(input logic [31:0] pc, input logic [4:0] rd);
    drive(pc, 32'h0000_1000, 32'h0, 32'h4, 5'd1, 5'd0, rd, LW, 1'b1, 4'h0, 1'b0, 2'b10,
          NOBRANCH, ALU_ADD, 1'b0, 2'b01);
  endtask

  task automatic drv_add(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd, input logic [1:0] rr);
    drive(pc, 32'h11, 32'h22, 32'h0, rs1, rs2, rd, LW, 1'b0, 4'h0, 1'b0, rr,
          NOBRANCH, ALU_ADD, 1'b0, 2'b00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.clear = 1'b0;
    drive('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0);

    // Reset state
    #12;
    chk("reset_fields", w_all_e, '0);
    chk("reset_valid", AW'(bus.valid_e), '0);
    chk("reset_cnt", AW'(bus.bubble_cnt), '0);
    chk("reset_stall", AW'(bus.stall_fd), '0);
    rst_n  = 1'b1;
    bus.en = 1'b1;

    // Normal advance: ADD x3, x1, x2
    drv_add(32'h100, 5'd1, 5'd2, 5'd3, 2'b11);
    tick();
    chk("add_fields", w_all_e, r_drv);
    chk("add_valid", AW'(bus.valid_e), 1);
    chk("add_stall", AW'(bus.stall_fd), 0);

    // Load-use: LW x5 then ADD x7, x5, x6
    drv_lw(32'h104, 5'd5);
    tick();
    chk("lw_fields", w_all_e, r_drv);
    drv_add(32'h108, 5'd5, 5'd6, 5'd7, 2'b11);
    r_held = r_drv;
    #1;
    chk("lu_stall", AW'(bus.stall_fd), 1);
    tick();
    chk("lu_bubble", w_all_e, '0);
    chk("lu_bubble_valid", AW'(bus.valid_e), 0);
    chk("lu_cnt1", AW'(bus.bubble_cnt), 1);
    chk("lu_stall_drop", AW'(bus.stall_fd), 0);
    tick();
    chk("lu_add_enters", w_all_e, r_held);
    chk("lu_add_valid", AW'(bus.valid_e), 1);

    // No false hazard: load to x0 followed by a reader of x0
    drv_lw(32'h10c, 5'd0);
    tick();
    drv_add(32'h110, 5'd0, 5'd0, 5'd8, 2'b11);
    #1;
    chk("x0_stall", AW'(bus.stall_fd), 0);
    tick();
    chk("x0_fields", w_all_e, r_drv);
    chk("x0_cnt", AW'(bus.bubble_cnt), 1);

    // No false hazard: LUI whose rs1 field matches but reads nothing
    drv_lw(32'h114, 5'd5);
    tick();
    drive(32'h118, 32'h0, 32'h0, 32'h1234_5000, 5'd5, 5'd5, 5'd9, LW, 1'b0, 4'h0, 1'b0, 2'b00,
          NOBRANCH, ALU_LUI, 1'b0, 2'b01);
    #1;
    chk("lui_stall", AW'(bus.stall_fd), 0);
    tick();
    chk("lui_fields", w_all_e, r_drv);
    chk("lui_cnt", AW'(bus.bubble_cnt), 1);

    // Hazard through rs2 only
    drv_lw(32'h11c, 5'd5);
    tick();
    drv_add(32'h120, 5'd1, 5'd5, 5'd10, 2'b01);
    #1;
    chk("rs2_stall", AW'(bus.stall_fd), 1);
    tick();
    chk("rs2_bubble_valid", AW'(bus.valid_e), 0);
    chk("rs2_cnt2", AW'(bus.bubble_cnt), 2);
    tick();
    chk("rs2_add_enters", w_all_e, r_drv);

    // Flush beats hazard
    drv_lw(32'h124, 5'd5);
    tick();
    drv_add(32'h128, 5'd5, 5'd6, 5'd11, 2'b11);
    bus.clear = 1'b1;
    #1;
    chk("flush_stall", AW'(bus.stall_fd), 0);
    tick();
    chk("flush_bubble", w_all_e, '0);
    chk("flush_valid", AW'(bus.valid_e), 0);
    chk("flush_cnt", AW'(bus.bubble_cnt), 2);
    bus.clear = 1'b0;

    // Enable hold: EX holds LW x5, ID reads x5, en=0 with clear=1
    drv_lw(32'h12c, 5'd5);
    r_held = r_drv;
    tick();
    bus.en = 1'b0;
    bus.clear = 1'b1;
    drv_add(32'h130, 5'd5, 5'd6, 5'd12, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_fields", w_all_e, r_held);
      chk("hold_valid", AW'(bus.valid_e), 1);
    end
    bus.clear = 1'b0;
    #1;
    chk("hold_stall_visible", AW'(bus.stall_fd), 1);
    tick();
    chk("hold_cnt", AW'(bus.bubble_cnt), 2);
    chk("hold_fields_nc", w_all_e, r_held);
    bus.en = 1'b1;

    // Saturation: this hazard reaches 3, further ones must stick at 3
    tick();
    chk("sat_cnt3", AW'(bus.bubble_cnt), 3);
    for (int i = 0; i < 4; i++) begin
      drv_lw(32'h200 + 32'(i * 8), 5'd5);
      tick();
      drv_add(32'h204 + 32'(i * 8), 5'd5, 5'd0, 5'd13, 2'b10);
      tick();
      chk("sat_bubble_valid", AW'(bus.valid_e), 0);
      chk("sat_cnt", AW'(bus.bubble_cnt), 3);
    end

    // Reset asserted mid-stall, released between edges
    drv_lw(32'h300, 5'd5);
    tick();
    drv_add(32'h304, 5'd5, 5'd0, 5'd14, 2'b10);
    #2;
    chk("pre_rst_stall", AW'(bus.stall_fd), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_fields", w_all_e, '0);
    chk("rst_valid", AW'(bus.valid_e), 0);
    chk("rst_cnt", AW'(bus.bubble_cnt), 0);
    chk("rst_stall", AW'(bus.stall_fd), 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_load", w_all_e, r_drv);
    chk("post_rst_valid", AW'(bus.valid_e), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
